// File: rtl/timer_irq_ctrl_pkg.sv
// Shared definitions for the memory-mapped interval timer: register offsets,
// TCON bit positions and the operating state derived from TCON.
package timer_irq_ctrl_pkg;

  localparam logic [31:0] TIMER_TH_OFS   = 32'h0000_0000;
  localparam logic [31:0] TIMER_TL_OFS   = 32'h0000_0004;
  localparam logic [31:0] TIMER_TCON_OFS = 32'h0000_0008;

  localparam int unsigned TCON_RUN  = 0;
  localparam int unsigned TCON_IEN  = 1;
  localparam int unsigned TCON_STAT = 2;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StPending
  } timerStateT;

  // The timer keeps no separate state register; its mode is a view of TCON.
  function automatic timerStateT stateOf(input logic [2:0] tcon);
    if (!tcon[TCON_RUN]) begin
      return StIdle;
    end else if (tcon[TCON_STAT]) begin
      return StPending;
    end else begin
      return StCount;
    end
  endfunction

endpackage

// File: rtl/timer_irq_ctrl_tick_gen.sv
// Prescaler for the interval timer: emits one tick every PRESCALE enabled
// cycles, or follows en directly when PRESCALE is 1.
module tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt;
  logic            atLast;

  assign atLast = (cnt == LastCnt);

  always_comb begin
    tick = (PRESCALE == 1) ? en : (en && atLast);
  end

  // Count is held at zero while stopped so a restart always waits a full period.
  always_ff @(posedge clk) begin
    if (reset || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Memory-mapped interval timer with reload register and a pending-interrupt
// flag; drives the control unit's IRQ input.
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr,
  input  logic        rd,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;

  logic        hitTh, hitTl, hitTcon;
  logic        wrTh, wrTl, wrTcon;
  logic        counting, tick, tlTick, overflow;
  timerStateT  state;

  assign hitTh   = (addr == BASE_ADDR + TIMER_TH_OFS);
  assign hitTl   = (addr == BASE_ADDR + TIMER_TL_OFS);
  assign hitTcon = (addr == BASE_ADDR + TIMER_TCON_OFS);

  assign wrTh   = wr && hitTh;
  assign wrTl   = wr && hitTl;
  assign wrTcon = wr && hitTcon;

  assign state    = stateOf(tcon);
  assign counting = (state != StIdle);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) uTickGen (
    .clk  (clk),
    .reset(reset),
    .en   (counting),
    .tick (tick)
  );

  // A software write to TL swallows the tick, including any overflow it would cause.
  assign tlTick   = tick && !wrTl;
  assign overflow = tlTick && (tl == 32'hFFFF_FFFF);

  assign irq = tcon[TCON_STAT] & tcon[TCON_IEN];

  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if (hitTh) begin
        rdata = th;
      end else if (hitTl) begin
        rdata = tl;
      end else if (hitTcon) begin
        rdata = {29'h0, tcon};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th   <= 32'h0;
      tl   <= 32'h0;
      tcon <= 3'b000;
    end else begin
      if (wrTh) begin
        th <= wdata;
      end

      if (wrTl) begin
        tl <= wdata;
      end else if (tlTick) begin
        tl <= overflow ? th : tl + 32'd1;
      end

      // An overflow in the same cycle as a clear still leaves the interrupt pending.
      if (wrTcon) begin
        tcon[TCON_RUN]  <= wdata[TCON_RUN];
        tcon[TCON_IEN]  <= wdata[TCON_IEN];
        tcon[TCON_STAT] <= wdata[TCON_STAT] | (wdata[TCON_IEN] & overflow);
      end else if (overflow) begin
        tcon[TCON_STAT] <= tcon[TCON_STAT] | tcon[TCON_IEN];
      end
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: a table of per-cycle bus vectors for the
// PRESCALE=1 instance, plus hand-written prescale and reset sequences.
module tb_timer_irq_ctrl;

  localparam logic [31:0] AddrTh   = 32'h4000_0000;
  localparam logic [31:0] AddrTl   = 32'h4000_0004;
  localparam logic [31:0] AddrTcon = 32'h4000_0008;
  localparam logic [31:0] AddrNone = 32'h4000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic [31:0] rdata;
  logic        irq;
  logic [31:0] rdata4;
  logic        irq4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expIrq;
  } vecT;

  vecT vecs[$];

  timer_irq_ctrl #(
    .BASE_ADDR(32'h4000_0000),
    .PRESCALE (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .wr   (wr),
    .rd   (rd),
    .rdata(rdata),
    .irq  (irq)
  );

  timer_irq_ctrl #(
    .BASE_ADDR(32'h4000_0000),
    .PRESCALE (4)
  ) dut4 (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .wr   (wr),
    .rd   (rd),
    .rdata(rdata4),
    .irq  (irq4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] er, input logic ei);
    vecT v;
    v.wr = w; v.rd = r; v.addr = a; v.wdata = d; v.expRdata = er; v.expIrq = ei;
    vecs.push_back(v);
  endfunction

  initial begin
    // Reset-state reads
    add(0, 1, AddrTh,   32'h0,         32'h0,         0);
    add(0, 1, AddrTl,   32'h0,         32'h0,         0);
    add(0, 1, AddrTcon, 32'h0,         32'h0,         0);
    add(0, 1, AddrNone, 32'h0,         32'h0,         0);
    // Wrap with interrupts enabled
    add(1, 0, AddrTh,   32'hFFFF_FFFD, 32'h0,         0);
    add(1, 0, AddrTl,   32'hFFFF_FFFD, 32'h0,         0);
    add(1, 1, AddrTcon, 32'h3,         32'h0,         0);
    add(0, 1, AddrTcon, 32'h0,         32'h3,         0);
    add(0, 1, AddrTl,   32'h0,         32'hFFFF_FFFE, 0);
    add(0, 1, AddrTl,   32'h0,         32'hFFFF_FFFF, 0);
    add(0, 1, AddrTl,   32'h0,         32'hFFFF_FFFD, 1);
    add(0, 1, AddrTcon, 32'h0,         32'h7,         1);
    // Clear colliding with the next overflow, then a plain clear
    add(1, 1, AddrTcon, 32'h3,         32'h7,         1);
    add(0, 1, AddrTcon, 32'h0,         32'h7,         1);
    add(1, 0, AddrTcon, 32'h3,         32'h0,         1);
    add(0, 1, AddrTcon, 32'h0,         32'h3,         0);
    add(1, 0, AddrTcon, 32'h0,         32'h0,         1);
    add(0, 1, AddrTl,   32'h0,         32'hFFFF_FFFE, 0);
    add(0, 1, AddrTcon, 32'h0,         32'h0,         0);
    // Overflow with interrupts disabled
    add(1, 0, AddrTcon, 32'h1,         32'h0,         0);
    add(0, 1, AddrTl,   32'h0,         32'hFFFF_FFFE, 0);
    add(0, 1, AddrTl,   32'h0,         32'hFFFF_FFFF, 0);
    add(0, 1, AddrTl,   32'h0,         32'hFFFF_FFFD, 0);
    add(0, 1, AddrTcon, 32'h0,         32'h1,         0);
    // TL writes while running, then stop
    add(1, 1, AddrTl,   32'd10,        32'hFFFF_FFFF, 0);
    add(0, 1, AddrTl,   32'h0,         32'd10,        0);
    add(1, 1, AddrTl,   32'h55,        32'd11,        0);
    add(0, 1, AddrTl,   32'h0,         32'h55,        0);
    add(0, 1, AddrTl,   32'h0,         32'h56,        0);
    add(1, 0, AddrTcon, 32'h0,         32'h0,         0);
    add(0, 1, AddrTl,   32'h0,         32'h58,        0);
    add(0, 1, AddrTl,   32'h0,         32'h58,        0);
    // Unmapped write is ignored
    add(1, 1, AddrNone, 32'hFFFF_FFFF, 32'h0,         0);
    add(0, 1, AddrTh,   32'h0,         32'hFFFF_FFFD, 0);
    add(0, 1, AddrTcon, 32'h0,         32'h0,         0);

    reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr = vecs[i].wr; rd = vecs[i].rd; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].expRdata);
      check($sformatf("vec%0d irq", i), {31'h0, irq}, {31'h0, vecs[i].expIrq});
      @(posedge clk);
    end

    // PRESCALE=4: TL advances once every four cycles
    @(negedge clk);
    reset = 1'b1; wr = 1'b0; rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; wr = 1'b1; addr = AddrTcon; wdata = 32'h1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr = 1'b0; rd = 1'b1; addr = AddrTl;
      #1;
      check($sformatf("pre4 tl k%0d", k), rdata4, 32'(k / 4));
      check($sformatf("pre4 irq k%0d", k), {31'h0, irq4}, 32'h0);
      @(posedge clk);
    end

    // Reset mid-count beats a simultaneous TCON write
    @(negedge clk);
    reset = 1'b1; wr = 1'b1; rd = 1'b0; addr = AddrTcon; wdata = 32'h3;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; wr = 1'b0; rd = 1'b1;
    addr = AddrTh;   #1; check("rst th", rdata4, 32'h0);
    addr = AddrTcon; #1; check("rst tcon", rdata4, 32'h0);
    addr = AddrTl;   #1; check("rst tl", rdata4, 32'h0);
    check("rst irq", {31'h0, irq4}, 32'h0);
    check("rst tcon dut1", dut.tcon == 3'b000 ? 32'h0 : 32'h1, 32'h0);
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst hold tl k%0d", k), rdata4, 32'h0);
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
